// File: rtl/p_table_pkg.sv
// Shared cipher tables: the byte substitution and its inverse.
package p_table_pkg;

  localparam logic [7:0] P_MUL = 8'd167;
  localparam logic [7:0] P_ADD = 8'd99;

  // Forward byte substitution; an odd multiplier keeps it a bijection on 0..255.
  function automatic logic [7:0] p_lookup(input logic [7:0] x);
    return (x * P_MUL) + P_ADD;
  endfunction

  // Inverse substitution found by searching the forward table, so it can never
  // drift out of step with p_lookup.
  function automatic logic [7:0] p_inv_lookup(input logic [7:0] y);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      if (p_lookup(8'(i)) == y) r = 8'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_round.sv
// One combinational inverse round: byte un-permute, then inverse M per 16-bit lane.
module dec_round
  import p_table_pkg::*;
(
  input  logic [63:0] idata,
  output logic [63:0] odata
);

  logic [7:0] a [8];

  // Undo the encryption byte shuffle: odd source bytes came from the top half.
  assign a[7] = idata[63:56];
  assign a[5] = idata[55:48];
  assign a[3] = idata[47:40];
  assign a[1] = idata[39:32];
  assign a[6] = idata[31:24];
  assign a[4] = idata[23:16];
  assign a[2] = idata[15:8];
  assign a[0] = idata[7:0];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] pu;
    logic [7:0] pv;
    logic [7:0] c;
    logic [7:0] xl;

    assign pu = p_inv_lookup(a[2*k+1]);
    assign pv = p_inv_lookup(a[2*k]);
    assign c  = pu ^ pv;
    // Each odd bit folds in the even bit just below it.
    assign xl = {c[7] ^ c[6], c[6], c[5] ^ c[4], c[4],
                 c[3] ^ c[2], c[2], c[1] ^ c[0], c[0]};
    assign odata[16*k +: 16] = {xl, {xl[6:0], xl[7]} ^ pv};
  end

endmodule

// File: rtl/dec_round_iter.sv
// Iterative block decryptor: applies in_nrounds inverse rounds, one per clock,
// through a single shared dec_round instance, with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | ready for a ciphertext, in_ready=1
//   RUN   | applying one inverse round per cycle, counter counts down
//   DONE  | result on out_data with out_valid=1, waiting for out_ready
module dec_round_iter #(
  parameter int MAX_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [3:0]  in_nrounds,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  state_t      state;
  logic [63:0] blk;
  logic [63:0] rnd_out;
  logic [3:0]  cnt;
  logic        err;

  dec_round u_dec_round (
    .idata (blk),
    .odata (rnd_out)
  );

  assign out_data = blk;
  assign out_err  = err;

  // Sequencing FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            blk      <= in_data;
            cnt      <= in_nrounds;
            in_ready <= 1'b0;
            if (in_nrounds > MAX_R) begin
              // Out-of-range count: report the ciphertext untouched.
              state     <= DONE;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end else if (in_nrounds == 4'd0) begin
              state     <= DONE;
              err       <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
              err   <= 1'b0;
            end
          end
        end
        RUN: begin
          blk <= rnd_out;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // No bypass: in_ready rises only in the cycle after consumption.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_round_iter.sv
// Self-checking bench for dec_round_iter with a transaction-level reference model.
module tb_dec_round_iter;

  localparam int MAX_R = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_nrounds = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_err;
  logic [63:0] rd_in = '0;
  logic [63:0] rd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_round_iter #(.MAX_ROUNDS(MAX_R)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_nrounds (in_nrounds),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  dec_round u_round (
    .idata (rd_in),
    .odata (rd_out)
  );

  // ---------------- reference cipher ----------------
  int m_pinv [256];

  function automatic int m_p(input int x);
    return (x * 167 + 99) % 256;
  endfunction

  // ciphertext byte j lands in intermediate byte amap(j)
  function automatic int amap(input int j);
    return (j < 4) ? 2 * j : 2 * (j - 4) + 1;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [63:0] m_dec(input logic [63:0] y);
    logic [7:0]  a [8];
    logic [7:0]  pu, pv, c, xl;
    logic [63:0] r;
    for (int j = 0; j < 8; j++) a[amap(j)] = y[8*j +: 8];
    r = '0;
    for (int k = 0; k < 4; k++) begin
      pu = 8'(m_pinv[a[2*k+1]]);
      pv = 8'(m_pinv[a[2*k]]);
      c  = pu ^ pv;
      xl = c ^ ((c & 8'h55) << 1);
      r[16*k +: 16] = {xl, rotl1(xl) ^ pv};
    end
    return r;
  endfunction

  function automatic logic [63:0] m_enc(input logic [63:0] x);
    logic [7:0]  a [8];
    logic [7:0]  xl, xr, c, pu, pv;
    logic [63:0] r;
    for (int k = 0; k < 4; k++) begin
      xl = x[16*k+8 +: 8];
      xr = x[16*k +: 8];
      c  = xl ^ ((xl & 8'h55) << 1);
      pv = rotl1(xl) ^ xr;
      pu = c ^ pv;
      a[2*k+1] = 8'(m_p(int'(pu)));
      a[2*k]   = 8'(m_p(int'(pv)));
    end
    r = '0;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = a[amap(j)];
    return r;
  endfunction

  function automatic logic [63:0] m_dec_n(input logic [63:0] y, input int n);
    logic [63:0] r;
    r = y;
    for (int i = 0; i < n; i++) r = m_dec(r);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  logic        m_busy = 1'b0;
  logic        m_err  = 1'b0;
  int          m_wait = 0;
  logic [63:0] m_data = '0;

  // m_wait = clock edges still to go before the result becomes visible
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        if (int'(in_nrounds) > MAX_R) begin
          m_err  = 1'b1;
          m_data = in_data;
          m_wait = 0;
        end else begin
          m_err  = 1'b0;
          m_data = m_dec_n(in_data, int'(in_nrounds));
          m_wait = int'(in_nrounds);
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  // Compare on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!m_busy));
    chk("out_valid", 64'(out_valid), 64'(m_busy && m_wait == 0));
    if (rst) begin
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_err", 64'(out_err), 64'h0);
    end else if (m_busy && m_wait == 0) begin
      chk("out_data", out_data, m_data);
      chk("out_err", 64'(out_err), 64'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic noise();
    in_valid   = 1'($urandom_range(0, 1));
    in_data    = {$urandom, $urandom};
    in_nrounds = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready still %b after %0d cycles", in_ready, w);
    end
  endtask

  task automatic run_job(input logic [63:0] d, input logic [3:0] n, input int hold,
                         output logic [63:0] got, output logic got_err, output int lat);
    wait_idle();
    in_valid   = 1'b1;
    in_data    = d;
    in_nrounds = n;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      noise();
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid low after %0d cycles", lat);
    end
    got     = out_data;
    got_err = out_err;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      noise();
      chk("hold_data", out_data, got);
      chk("hold_in_ready", 64'(in_ready), 64'h0);
      @(posedge clk); #1;
    end
    noise();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("consumed_valid", 64'(out_valid), 64'h0);
    chk("consumed_in_ready", 64'(in_ready), 64'h1);
  endtask

  initial begin
    logic [63:0] x, got, exp;
    logic        got_err;
    int          lat, hold;
    logic [3:0]  n;
    logic [63:0] fixed [3];

    for (int i = 0; i < 256; i++) m_pinv[m_p(i)] = i;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // hand-computed anchors for the model
    chk("p_0", 64'(m_p(0)), 64'h63);
    chk("p_1", 64'(m_p(1)), 64'h0A);
    chk("p_2", 64'(m_p(2)), 64'hB1);
    chk("pinv_0", 64'(m_pinv[0]), 64'h1B);
    chk("model_dec_zero", m_dec(64'h0), 64'h001B001B001B001B);
    rd_in = 64'h0;
    #1 chk("round_zero", rd_out, 64'h001B001B001B001B);

    // single-round inverse property on the standalone round
    fixed[0] = 64'h0;
    fixed[1] = 64'hFFFFFFFFFFFFFFFF;
    fixed[2] = 64'h0123456789ABCDEF;
    for (int i = 0; i < 3; i++) begin
      chk("model_roundtrip", m_dec(m_enc(fixed[i])), fixed[i]);
      rd_in = m_enc(fixed[i]);
      #1 chk("round_inverse_fixed", rd_out, fixed[i]);
    end
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      rd_in = m_enc(x);
      #1 chk("round_inverse_rand", rd_out, x);
    end

    @(posedge clk); #1;

    // two rounds back to the plaintext, result at T+3
    run_job(m_enc(m_enc(64'h0123456789ABCDEF)), 4'd2, 0, got, got_err, lat);
    chk("two_round_data", got, 64'h0123456789ABCDEF);
    chk("two_round_err", 64'(got_err), 64'h0);
    chk("two_round_lat", 64'(lat), 64'd3);

    // zero rounds pass straight through at T+1
    run_job(64'hFFEEDDCCBBAA0099, 4'd0, 1, got, got_err, lat);
    chk("zero_round_data", got, 64'hFFEEDDCCBBAA0099);
    chk("zero_round_lat", 64'(lat), 64'd1);

    // counts over the limit flag an error and leave the data alone
    run_job(64'h1122334455667788, 4'd9, 0, got, got_err, lat);
    chk("over_data", got, 64'h1122334455667788);
    chk("over_err", 64'(got_err), 64'h1);
    chk("over_lat", 64'(lat), 64'd1);
    run_job(64'hA5A5A5A5A5A5A5A5, 4'd15, 0, got, got_err, lat);
    chk("over15_err", 64'(got_err), 64'h1);
    chk("over15_data", got, 64'hA5A5A5A5A5A5A5A5);

    // the largest legal count
    x = 64'hDEADBEEFCAFEF00D;
    run_job(x, 4'd8, 0, got, got_err, lat);
    chk("max_round_data", got, m_dec_n(x, 8));
    chk("max_round_err", 64'(got_err), 64'h0);
    chk("max_round_lat", 64'(lat), 64'd9);

    // consumer stalls five cycles
    run_job(m_enc(m_enc(m_enc(64'h0F1E2D3C4B5A6978))), 4'd3, 5, got, got_err, lat);
    chk("stall_data", got, 64'h0F1E2D3C4B5A6978);
    chk("stall_lat", 64'(lat), 64'd4);

    // reset during the third RUN cycle of an 8-round job
    wait_idle();
    in_valid   = 1'b1;
    in_data    = 64'h0BADF00D0BADF00D;
    in_nrounds = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_in_ready", 64'(in_ready), 64'h1);
      chk("post_rst_out_valid", 64'(out_valid), 64'h0);
      @(posedge clk); #1;
    end
    x = 64'h0123456789ABCDEF;
    run_job(m_enc(m_enc(m_enc(m_enc(x)))), 4'd4, 0, got, got_err, lat);
    chk("post_rst_job", got, x);
    chk("post_rst_lat", 64'(lat), 64'd5);

    // randomized jobs
    for (int t = 0; t < 40; t++) begin
      x    = {$urandom, $urandom};
      n    = 4'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      exp  = (int'(n) > MAX_R) ? x : m_dec_n(x, int'(n));
      run_job(x, n, hold, got, got_err, lat);
      chk("rand_data", got, exp);
      chk("rand_err", 64'(got_err), 64'(int'(n) > MAX_R));
      chk("rand_lat", 64'(lat), 64'((n == 4'd0 || int'(n) > MAX_R) ? 1 : int'(n) + 1));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_round_iter.md
DEC_ROUND_ITER -- requirements
Module: dec_round_iter

Interface
REQ-001 The block SHALL have parameter MAX_ROUNDS, default 8, the largest accepted round count (1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, a ciphertext block is offered.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept a new ciphertext.
REQ-006 The block SHALL have port in_data, input, 64, the ciphertext block.
REQ-007 The block SHALL have port in_nrounds, input, 4, the number of inverse rounds to apply.
REQ-008 The block SHALL have port out_valid, output, 1, out_data holds a result.
REQ-009 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-010 The block SHALL have port out_data, output, 64, the decrypted block.
REQ-011 The block SHALL have port out_err, output, 1, qualified by out_valid: in_nrounds exceeded MAX_ROUNDS.

Function
REQ-012 One inverse round SHALL be the exact inverse of enc_round, applied in two steps.
REQ-013 Step 1, byte un-permute: input bytes y7..y0 (y7 = [63:56]) map to a7=y7, a5=y6, a3=y5, a1=y4, a6=y3, a4=y2, a2=y1, a0=y0.
REQ-014 Step 2, inverse M on each 16-bit lane {u,v} of a (u = high byte): pu=p_inv_lookup(u), pv=p_inv_lookup(v), c=pu^pv.
REQ-015 Step 2 SHALL produce xl={c7^c6, c6, c5^c4, c4, c3^c2, c2, c1^c0, c0}, xr=rotl1(xl)^pv, lane result {xl,xr}.
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid, latch in_data into the state register and in_nrounds into the round counter.
REQ-018 From IDLE, a latched count of 0 SHALL go to DONE and a count of 1..MAX_ROUNDS SHALL go to RUN.
REQ-019 A count above MAX_ROUNDS SHALL go to DONE with the data unchanged and out_err=1.
REQ-020 RUN: each cycle, state register <= inverse_round(state register) and counter decrements; on the cycle the counter reaches 0, go to DONE.
REQ-021 Latency: acceptance in cycle T with N valid rounds SHALL give out_valid in cycle T+N+1; N=0 gives T+1.
REQ-022 DONE: out_valid=1 and out_data/out_err held stable until out_valid and out_ready are both high, then go to IDLE.
REQ-023 in_ready SHALL be 0 in RUN and DONE; the block takes no new input in the cycle a result is consumed (no bypass).
REQ-024 out_data SHALL always equal the state register; only out_valid qualifies it.
REQ-025 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-026 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, the state register and counter SHALL be 0, and out_valid=0, out_err=0, in_ready=1.
REQ-028 rst asserted mid-RUN or mid-DONE SHALL abort immediately, discard the result, and emit no out_valid pulse after release.

Structure
REQ-029 p_table_pkg SHALL add p_inv_lookup, derived from the p_lookup table, with p_inv_lookup(p_lookup(x))==x for all 256 x.
REQ-030 The FSM state enum SHALL be local to the module; the package SHALL hold only shared cipher tables and functions.
REQ-031 The combinational inverse round SHALL be one sub-module, dec_round (idata 64 in, odata 64 out), instantiated once and used iteratively.

Verification
REQ-032 Scenario: dec_round(enc_round(x))==x for x = 0x0, 0xFFFFFFFFFFFFFFFF, 0x0123456789ABCDEF and 1000 random x.
REQ-033 Scenario: in_data=enc_round(enc_round(0x0123456789ABCDEF)), nrounds=2 -> out_data=0x0123456789ABCDEF at T+3, out_err=0.
REQ-034 Scenario: nrounds=0, in_data=0xFFEEDDCCBBAA0099 -> out_data=0xFFEEDDCCBBAA0099 at T+1.
REQ-035 Scenario: nrounds=9 with MAX_ROUNDS=8 -> out_valid at T+1, out_err=1, out_data=in_data.
REQ-036 Scenario: out_ready held low for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; accepted in the cycle out_ready rises.
REQ-037 Scenario: rst pulse in the 3rd RUN cycle of an 8-round job -> in_ready=1 and out_valid=0 after release; the next job gives the correct result.
